// File: rtl/custom_axi_ip_mc_if.sv
// Job request/result bundle for the multi-channel increment engine.
// The engine side uses the slave modport and the requester side uses the master modport.
interface custom_axi_ip_mc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int ITER_W     = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                         start_i;
    logic [CH_W-1:0]              ch_sel_i;
    logic [DATA_WIDTH-1:0]        data_i;
    logic [ITER_W-1:0]            iter_i;
    logic                         clear_i;
    logic [NUM_CH*DATA_WIDTH-1:0] result_o;
    logic                         busy_o;
    logic                         done_o;
    logic                         err_o;
    logic [1:0]                   status_o;

    modport master (
        output start_i, ch_sel_i, data_i, iter_i, clear_i,
        input  result_o, busy_o, done_o, err_o, status_o
    );

    modport slave (
        input  start_i, ch_sel_i, data_i, iter_i, clear_i,
        output result_o, busy_o, done_o, err_o, status_o
    );
endinterface

// File: rtl/custom_axi_ip_mc.sv
// Multi-channel increment engine: seeds an accumulator, increments it iter_i times
// and stores the sum in the selected result channel, flagging wrap or bad requests.
package custom_axi_ip_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } status_e;
endpackage

module custom_axi_ip_mc
    import custom_axi_ip_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int ITER_W     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    custom_axi_ip_mc_if.slave    bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    status_e               state_reg, state_next;
    logic [DATA_WIDTH-1:0] acc_reg,   acc_next;
    logic [ITER_W-1:0]     cnt_reg,   cnt_next;
    logic [CH_W-1:0]       ch_reg,    ch_next;
    logic                  err_reg,   err_next;
    logic [DATA_WIDTH-1:0] res_reg  [NUM_CH];
    logic [DATA_WIDTH-1:0] res_next [NUM_CH];

    logic                  req_ok;
    logic                  acc_full;
    logic                  last_step;
    logic [DATA_WIDTH-1:0] acc_inc;

    assign req_ok    = (bus.iter_i != '0) && (int'(bus.ch_sel_i) < NUM_CH);
    assign acc_full  = &acc_reg;
    assign last_step = (cnt_reg == ITER_W'(1));
    assign acc_inc   = acc_reg + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ch_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ch_reg    <= ch_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ch_next    = ch_reg;
        err_next   = bus.clear_i ? 1'b0 : err_reg;
        for (int i = 0; i < NUM_CH; i++) begin
            res_next[i] = bus.clear_i ? '0 : res_reg[i];
        end

        unique case (state_reg)
            IDLE: begin
                if (bus.start_i) begin
                    if (req_ok) begin
                        acc_next   = bus.data_i;
                        cnt_next   = bus.iter_i;
                        ch_next    = bus.ch_sel_i;
                        state_next = BUSY;
                    end else begin
                        err_next   = 1'b1;
                        state_next = ERROR;
                    end
                end
            end
            BUSY: begin
                acc_next = acc_inc;
                cnt_next = cnt_reg - 1'b1;
                // Wrap detection outranks completion so a wrapped sum is never stored.
                if (acc_full) begin
                    err_next   = 1'b1;
                    state_next = ERROR;
                end else if (last_step) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_reg == CH_W'(i)) begin
                            res_next[i] = acc_inc;
                        end
                    end
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            ERROR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_res
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    res_reg[gi] <= '0;
                end else begin
                    res_reg[gi] <= res_next[gi];
                end
            end
            assign bus.result_o[gi*DATA_WIDTH +: DATA_WIDTH] = res_reg[gi];
        end
    endgenerate

    assign bus.busy_o   = (state_reg == BUSY);
    assign bus.done_o   = (state_reg == DONE);
    assign bus.err_o    = err_reg;
    assign bus.status_o = state_reg;
endmodule

// File: tb/tb_custom_axi_ip_mc.sv
// Directed bench for custom_axi_ip_mc: a 4-channel instance for the main scenarios
// and a 3-channel instance for the out-of-range channel case.
module tb_custom_axi_ip_mc;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    custom_axi_ip_mc_if #(.DATA_WIDTH(32), .NUM_CH(4), .ITER_W(4)) bus ();
    custom_axi_ip_mc_if #(.DATA_WIDTH(32), .NUM_CH(3), .ITER_W(4)) bus3 ();

    custom_axi_ip_mc #(.DATA_WIDTH(32), .NUM_CH(4), .ITER_W(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    custom_axi_ip_mc #(.DATA_WIDTH(32), .NUM_CH(3), .ITER_W(4)) dut3 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus3.slave)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("check %-18s got=%0h exp=%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [1:0] st, input logic err);
        check({tag, ".status"}, 128'(bus.status_o), 128'(st));
        check({tag, ".busy"},   128'(bus.busy_o),   128'(st == 2'd1));
        check({tag, ".done"},   128'(bus.done_o),   128'(st == 2'd2));
        check({tag, ".err"},    128'(bus.err_o),    128'(err));
    endtask

    task automatic start_job(input logic [1:0] ch, input logic [31:0] data, input logic [3:0] iter);
        bus.start_i  = 1'b1;
        bus.ch_sel_i = ch;
        bus.data_i   = data;
        bus.iter_i   = iter;
    endtask

    initial begin
        bus.start_i = 0; bus.ch_sel_i = 0; bus.data_i = 0; bus.iter_i = 0; bus.clear_i = 0;
        bus3.start_i = 0; bus3.ch_sel_i = 0; bus3.data_i = 0; bus3.iter_i = 0; bus3.clear_i = 0;

        // Reset state
        tick(); tick();
        check_state("rst", 2'd0, 1'b0);
        check("rst.result", 128'(bus.result_o), 128'h0);
        rst_ni = 1'b1;

        // Basic job: ch2, 0x10, 3 increments
        start_job(2'd2, 32'h10, 4'd3);
        tick(); bus.start_i = 0;
        check_state("j1.b1", 2'd1, 1'b0);
        tick(); check_state("j1.b2", 2'd1, 1'b0);
        tick(); check_state("j1.b3", 2'd1, 1'b0);
        tick(); check_state("j1.done", 2'd2, 1'b0);
        check("j1.result", 128'(bus.result_o), {32'h0, 32'h13, 32'h0, 32'h0});
        tick(); check_state("j1.idle", 2'd0, 1'b0);

        // Overflow: ch1, 0xFFFFFFFE, 3 increments -> ERROR after 2 BUSY cycles
        start_job(2'd1, 32'hFFFF_FFFE, 4'd3);
        tick(); bus.start_i = 0;
        check_state("ov.b1", 2'd1, 1'b0);
        tick(); check_state("ov.b2", 2'd1, 1'b0);
        tick(); check_state("ov.err", 2'd3, 1'b1);
        check("ov.result", 128'(bus.result_o), {32'h0, 32'h13, 32'h0, 32'h0});
        tick(); check_state("ov.idle", 2'd0, 1'b1);

        // iter=0 -> immediate ERROR, then clear
        start_job(2'd0, 32'h55, 4'd0);
        tick(); bus.start_i = 0;
        check_state("it0.err", 2'd3, 1'b1);
        tick(); check_state("it0.idle", 2'd0, 1'b1);
        bus.clear_i = 1;
        tick(); bus.clear_i = 0;
        check_state("clr", 2'd0, 1'b0);
        check("clr.result", 128'(bus.result_o), 128'h0);

        // start held high: job A then job B, one per IDLE visit
        start_job(2'd0, 32'h5, 4'd2);
        tick();
        bus.ch_sel_i = 2'd3; bus.data_i = 32'h20; bus.iter_i = 4'd1;
        check("hold.s1", 128'(bus.status_o), 128'd1);
        tick(); check("hold.s2", 128'(bus.status_o), 128'd1);
        tick(); check("hold.s3", 128'(bus.status_o), 128'd2);
        check("hold.resA", 128'(bus.result_o), {32'h0, 32'h0, 32'h0, 32'h7});
        tick(); check("hold.s4", 128'(bus.status_o), 128'd0);
        tick(); check("hold.s5", 128'(bus.status_o), 128'd1);
        bus.start_i = 0;
        tick(); check("hold.s6", 128'(bus.status_o), 128'd2);
        check("hold.resB", 128'(bus.result_o), {32'h21, 32'h0, 32'h0, 32'h7});
        tick(); check("hold.s7", 128'(bus.status_o), 128'd0);

        // Reset during the second BUSY cycle
        start_job(2'd1, 32'h100, 4'd3);
        tick(); bus.start_i = 0;
        tick(); check("mid.busy", 128'(bus.status_o), 128'd1);
        #2 rst_ni = 1'b0;
        #1;
        check_state("mid.rst", 2'd0, 1'b0);
        check("mid.result", 128'(bus.result_o), 128'h0);
        tick(); rst_ni = 1'b1;
        start_job(2'd1, 32'h100, 4'd1);
        tick(); bus.start_i = 0;
        check_state("post.busy", 2'd1, 1'b0);
        tick(); check_state("post.done", 2'd2, 1'b0);
        check("post.result", 128'(bus.result_o), {32'h0, 32'h0, 32'h101, 32'h0});
        tick();

        // clear coinciding with a result write: written channel wins
        start_job(2'd3, 32'h7, 4'd1);
        tick(); bus.start_i = 0; bus.clear_i = 1;
        tick(); bus.clear_i = 0;
        check("clrwr.result", 128'(bus.result_o), {32'h8, 32'h0, 32'h0, 32'h0});
        tick();

        // clear coinciding with ERROR entry: err wins
        start_job(2'd0, 32'h0, 4'd0);
        bus.clear_i = 1;
        tick(); bus.start_i = 0; bus.clear_i = 0;
        check_state("clrerr", 2'd3, 1'b1);
        check("clrerr.result", 128'(bus.result_o), 128'h0);
        tick();

        // NUM_CH=3: channel 3 is out of range, channel 2 is valid
        bus3.start_i = 1; bus3.ch_sel_i = 2'd3; bus3.data_i = 32'h1; bus3.iter_i = 4'd1;
        tick(); bus3.start_i = 0;
        check("n3.status", 128'(bus3.status_o), 128'd3);
        check("n3.err", 128'(bus3.err_o), 128'd1);
        check("n3.result", 128'(bus3.result_o), 128'h0);
        tick();
        bus3.start_i = 1; bus3.ch_sel_i = 2'd2; bus3.data_i = 32'hA; bus3.iter_i = 4'd2;
        tick(); bus3.start_i = 0;
        tick(); tick();
        check("n3.done", 128'(bus3.done_o), 128'd1);
        check("n3.result2", 128'(bus3.result_o), 128'({32'hC, 32'h0, 32'h0}));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
